alu32_byteseq: RTL
==================

# alu32_byteseq

Byte-serial sequencer that runs 32-bit ALU operations through a single 8-bit ALU slice over several clock cycles. It accepts one operation at a time on a valid/ready input handshake and steps the slice through bytes 0..NBYTES-1, LSB first, chaining carry in a register. It resolves SLT after the MSB byte and returns result, zero, carry-out and overflow on a valid/ready output handshake. It sits between the decode stage and the shared 8-bit arithmetic slice, so one slice serves full-width operations.

## Interface
- NBYTES, 4, number of byte slices; datapath width W = 8*NBYTES; NBYTES ≥ 2.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request; high only in IDLE.
- src1  in  W  operand A; sampled on input handshake.
- src2  in  W  operand B; sampled on input handshake.
- alu_ctrl  in  4  operation code; bit3 = A_invert, bit2 = B_invert, bits[1:0] = operation (00 AND, 01 OR, 10 ADD, 11 LESS).
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  W  operation result.
- zero  out  1  result == 0.
- cout  out  1  carry out of the MSB byte; ADD/SUB/SLT only, else 0.
- overflow  out  1  signed overflow; ADD/SUB only, else 0.

## Operation
- Legal codes are 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT and 1100 NOR.
  - Any other code completes with result = 0, zero = 1, cout = 0 and overflow = 0.
  - Illegal codes take the non-SLT latency.
- Carry-in to byte 0 equals B_invert (alu_ctrl[2]). The carry register holds the slice carry-out between bytes.
- Per byte k:
  - Effective operands: a = src1 byte k XOR {8{A_invert}}; b = src2 byte k XOR {8{B_invert}}.
  - AND/OR/NOR: bitwise on a and b.
  - ADD/SUB/LESS: sum = a + b + carry. The sum byte is written into the result register and the carry register is updated.
- SLT:
  - The bytes run as SUB, and the difference is discarded.
  - set = diff[W-1] XOR ovf, where ovf uses the rule below.
  - Final result = {(W-1){0}, set}.
- Overflow, for ADD and SUB: ovf = (aW-1 == bW-1) && (sumW-1 != aW-1). These use the effective (post-invert) MSBs.
- zero is computed on the final W-bit result.
- States:
  - IDLE: in_ready = 1. On in_valid, latch src1, src2 and alu_ctrl; clear byte counter; go to RUN.
  - RUN: process byte counter, then increment it. After byte NBYTES-1, go to FIX if SLT, else to DONE.
  - FIX: form SLT result and flags; go to DONE.
  - DONE: out_valid = 1. On out_ready, go to IDLE.
- Backpressure:
  - While out_valid = 1 and out_ready = 0, result, zero, cout and overflow stay stable.
  - in_valid is ignored whenever in_ready = 0.
- Reset, including assertion mid-operation:
  - State goes to IDLE, byte counter = 0, carry = 0.
  - Outputs: in_ready = 1 after release, out_valid = 0, result = 0, zero = 0, cout = 0, overflow = 0.
  - Any in-flight operation is discarded.

## Timing
- Input handshake at edge E0 (in_valid && in_ready).
- Byte k is processed at edge E(k+1).
- Latency from E0 to out_valid high:
  - Non-SLT: NBYTES edges (4 at default).
  - SLT: NBYTES+1 edges (5 at default).
- Output handshake at edge Ed; in_ready rises after Ed.
- Minimum issue interval at default parameters with out_ready held high:
  - Non-SLT: 6 cycles.
  - SLT: 7 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs except in_ready from state.

## Test plan
- ADD: src1 = 0x7FFFFFFF, src2 = 0x00000001, ctrl 0010 → result 0x80000000, overflow = 1, cout = 0, zero = 0, out_valid 4 cycles after accept.
- SUB: src1 = 0x00000005, src2 = 0x00000005, ctrl 0110 → result 0, zero = 1, cout = 1, overflow = 0. SUB 0x80000000 − 0x00000001 → 0x7FFFFFFF, overflow = 1.
- SLT:
  - 0xFFFFFFFF vs 0x00000001 → result 1, 5-cycle latency.
  - 0x7FFFFFFF vs 0x80000000 → result 0 (overflow case).
- Logic ops on src1 = 0x0F0F0000, src2 = 0x00F0F0F0:
  - AND → 0x00000000, zero = 1.
  - OR → 0x0FFFF0F0.
  - NOR → 0xF0000F0F.
  - Illegal code 1010 → 0.
- Handshake:
  - Hold out_ready = 0 for 10 cycles → outputs stable and in_ready = 0.
  - A second in_valid during the operation is ignored.
  - After out_ready the next request is accepted the following cycle.
- Reset at byte 2 of an ADD → out_valid = 0, result = 0, in_ready = 1 after release. A fresh ADD 3 + 4 returns 7 with normal latency.

Source files
------------

// File: rtl/alu32_byteseq.sv
// -----------------------------------------------------------------------------
// alu32_byteseq
//
// Runs full-width ALU operations through a single 8-bit slice, one byte per
// clock, LSB first, with the slice carry chained through a register between
// bytes. SLT needs one extra cycle after the MSB byte to turn the difference
// into a 0/1 result. One operation is in flight at a time.
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid_i   operation request
//   in_ready_o   request can be accepted (IDLE only)
//   src1_i       operand A, sampled on the input handshake
//   src2_i       operand B, sampled on the input handshake
//   alu_ctrl_i   {A_invert, B_invert, op[1:0]}; op 00 AND, 01 OR, 10 ADD, 11 LESS
//   out_valid_o  result available (DONE only)
//   out_ready_i  consumer accepts the result
//   result_o     operation result
//   zero_o       result == 0
//   cout_o       carry out of the MSB byte (ADD/SUB/SLT, else 0)
//   overflow_o   signed overflow (ADD/SUB, else 0)
// -----------------------------------------------------------------------------
module alu32_byteseq #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [8*NBYTES-1:0]   src1_i,
    input  logic [8*NBYTES-1:0]   src2_i,
    input  logic [3:0]            alu_ctrl_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [8*NBYTES-1:0]   result_o,
    output logic                  zero_o,
    output logic                  cout_o,
    output logic                  overflow_o
);

    localparam int W     = 8 * NBYTES;
    localparam int CNT_W = $clog2(NBYTES);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_NOR = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     src1_q, src1_d;
    logic [W-1:0]     src2_q, src2_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic [W-1:0]     result_q, result_d;
    logic             zero_q, zero_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             slt_set_q, slt_set_d;

    // Byte slice datapath
    logic [CNT_W+2:0] bit_base;
    logic [7:0]       a_byte;
    logic [7:0]       b_byte;
    logic [8:0]       sum9;
    logic [7:0]       slice_byte;
    logic             byte_ovf;
    logic             ctrl_legal;
    logic             is_addsub;
    logic             is_slt;

    function automatic logic legal_code(input logic [3:0] c);
        case (c)
            CTRL_AND, CTRL_OR, CTRL_ADD, CTRL_SUB, CTRL_SLT, CTRL_NOR: return 1'b1;
            default:                                                  return 1'b0;
        endcase
    endfunction

    assign bit_base   = {cnt_q, 3'b000};
    assign a_byte     = src1_q[bit_base +: 8] ^ {8{ctrl_q[3]}};
    assign b_byte     = src2_q[bit_base +: 8] ^ {8{ctrl_q[2]}};
    assign sum9       = {1'b0, a_byte} + {1'b0, b_byte} + {8'd0, carry_q};
    // Only meaningful on the MSB byte, where it is the full-width overflow.
    assign byte_ovf   = (a_byte[7] == b_byte[7]) && (sum9[7] != a_byte[7]);
    assign ctrl_legal = legal_code(ctrl_q);
    assign is_addsub  = (ctrl_q == CTRL_ADD) || (ctrl_q == CTRL_SUB);
    assign is_slt     = (ctrl_q == CTRL_SLT);

    always_comb begin
        case (ctrl_q[1:0])
            2'b00:   slice_byte = a_byte & b_byte;
            2'b01:   slice_byte = a_byte | b_byte;
            default: slice_byte = sum9[7:0];
        endcase
    end

    // NOTE: every signal assigned below gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        src1_d    = src1_q;
        src2_d    = src2_q;
        ctrl_d    = ctrl_q;
        result_d  = result_q;
        zero_d    = zero_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        slt_set_d = slt_set_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    src1_d  = src1_i;
                    src2_d  = src2_i;
                    ctrl_d  = alu_ctrl_i;
                    cnt_d   = '0;
                    // B_invert doubles as the +1 of two's-complement subtract.
                    carry_d = alu_ctrl_i[2];
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                // Illegal codes write zero bytes so they finish as result 0.
                result_d[bit_base +: 8] = ctrl_legal ? slice_byte : 8'h00;
                if (ctrl_q[1]) begin
                    carry_d = sum9[8];
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BYTE) begin
                    cnt_d     = '0;
                    zero_d    = (result_d == '0);
                    cout_d    = (is_addsub || is_slt) && sum9[8];
                    ovf_d     = is_addsub && byte_ovf;
                    slt_set_d = sum9[7] ^ byte_ovf;
                    state_d   = is_slt ? S_FIX : S_DONE;
                end
            end

            S_FIX: begin
                result_d = {{(W-1){1'b0}}, slt_set_q};
                zero_d   = ~slt_set_q;
                state_d  = S_DONE;
            end

            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: operand and result registers are plain flops, not a memory array,
    // so all of them are reset; a mid-operation reset leaves nothing stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            src1_q    <= '0;
            src2_q    <= '0;
            ctrl_q    <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            slt_set_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge value, independent of statement order.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            ctrl_q    <= ctrl_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
            slt_set_q <= slt_set_d;
        end
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign out_valid_o = (state_q == S_DONE);
    assign result_o    = result_q;
    assign zero_o      = zero_q;
    assign cout_o      = cout_q;
    assign overflow_o  = ovf_q;

endmodule
